// File: rtl/clk_phase_pkg.sv
// Shared types and default constants for the divided-clock phase decoder.
package clk_phase_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int HALF_PERIOD_DEF = 5;
  localparam int TOL_DEF         = 0;
  localparam int LOCK_COUNT_DEF  = 8;
  localparam int TIMEOUT_DEF     = 32;
  localparam int NUM_PHASES_DEF  = 4;
  localparam int CNT_W_DEF       = 8;

  // True when a measured half-period lies within tol of the expected value.
  function automatic logic within_tol(input int meas, input int expected, input int tol);
    int diff;
    diff = (meas > expected) ? (meas - expected) : (expected - meas);
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/clk_phase_decoder_sync_edge_det.sv
// Two-flop synchroniser with a history flop and registered single-cycle
// rise/fall strobes for an asynchronous level input.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;
  logic rise_q, fall_q;
  logic rise_d, fall_d;

  // Next-state: shift the sampled level and compare the two newest synchronised samples.
  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/clk_phase_decoder.sv
// Receives the divided clock, measures its half-period, runs the lock FSM and
// drives a one-hot phase ring for the core sequencer while locked.
module clk_phase_decoder
  import clk_phase_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int TOL         = TOL_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int NUM_PHASES  = NUM_PHASES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                          ext_clk,
  input  logic                          ext_reset_n,
  input  logic                          clk_in,
  input  logic                          err_clear,
  output logic                          rise,
  output logic                          fall,
  output logic [NUM_PHASES-1:0]         phase,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic                          locked,
  output logic [CNT_W-1:0]              half_cnt,
  output logic                          err_period,
  output logic                          err_timeout
);

  localparam int IDX_W = $clog2(NUM_PHASES);
  localparam int GC_W  = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] GAP_MAX_C  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST_C = IDX_W'(NUM_PHASES - 1);
  localparam logic [GC_W-1:0]  GOOD_END_C = GC_W'(LOCK_COUNT - 1);

  logic ev_rise_s, ev_fall_s, edge_s, good_s, timeout_s;
  logic err_p_new_s, err_t_new_s;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       gap_q, gap_d;
  logic [GC_W-1:0]        good_cnt_q, good_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   rise_q, rise_d, fall_q, fall_d;
  logic [NUM_PHASES-1:0]  phase_q, phase_d;
  logic [IDX_W-1:0]       phase_idx_q, phase_idx_d;
  logic                   locked_q, locked_d;
  logic [CNT_W-1:0]       half_cnt_q, half_cnt_d;
  logic                   err_period_q, err_period_d;
  logic                   err_timeout_q, err_timeout_d;

  sync_edge_det u_sync (
    .clk   (ext_clk),
    .rst_n (ext_reset_n),
    .din   (clk_in),
    .rise  (ev_rise_s),
    .fall  (ev_fall_s)
  );

  assign edge_s    = ev_rise_s | ev_fall_s;
  assign good_s    = within_tol(32'(gap_q), HALF_PERIOD, TOL);
  assign timeout_s = (gap_q >= TIMEOUT_C);

  // Next-state for gap counter, lock FSM, phase ring, outputs and sticky flags.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    idx_d       = idx_q;
    err_p_new_s = 1'b0;
    err_t_new_s = 1'b0;

    if (edge_s) begin
      gap_d = CNT_W'(1);
    end else if (gap_q == GAP_MAX_C) begin
      gap_d = gap_q;
    end else begin
      gap_d = gap_q + CNT_W'(1);
    end

    // Timeout is evaluated ahead of any edge arriving in the same cycle.
    case (state_q)
      IDLE: begin
        idx_d = {IDX_W{1'b0}};
        if (edge_s) begin
          state_d    = ACQ;
          good_cnt_d = {GC_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ACQ: begin
        idx_d = {IDX_W{1'b0}};
        if (timeout_s) begin
          state_d     = IDLE;
          good_cnt_d  = {GC_W{1'b0}};
          err_t_new_s = 1'b1;
        end else if (edge_s && good_s) begin
          if (good_cnt_q == GOOD_END_C) begin
            state_d    = LOCKED;
            good_cnt_d = {GC_W{1'b0}};
          end else begin
            good_cnt_d = good_cnt_q + GC_W'(1);
          end
        end else if (edge_s) begin
          good_cnt_d = {GC_W{1'b0}};
        end else begin
          state_d = ACQ;
        end
      end
      LOCKED: begin
        if (timeout_s) begin
          state_d     = IDLE;
          idx_d       = {IDX_W{1'b0}};
          err_t_new_s = 1'b1;
        end else if (edge_s && !good_s) begin
          state_d     = ACQ;
          good_cnt_d  = {GC_W{1'b0}};
          idx_d       = {IDX_W{1'b0}};
          err_p_new_s = 1'b1;
        end else if (ev_rise_s) begin
          idx_d = (idx_q == IDX_LAST_C) ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));
        end else begin
          state_d = LOCKED;
        end
      end
      default: begin
        state_d    = IDLE;
        good_cnt_d = {GC_W{1'b0}};
        idx_d      = {IDX_W{1'b0}};
      end
    endcase

    rise_d     = ev_rise_s;
    fall_d     = ev_fall_s;
    half_cnt_d = edge_s ? gap_q : half_cnt_q;
    locked_d   = (state_q == LOCKED);
    if (locked_d) begin
      phase_idx_d = idx_q;
      phase_d     = NUM_PHASES'(1) << idx_q;
    end else begin
      phase_idx_d = {IDX_W{1'b0}};
      phase_d     = {NUM_PHASES{1'b0}};
    end

    // A new error beats a simultaneous clear.
    err_period_d  = err_p_new_s | (err_period_q  & ~err_clear);
    err_timeout_d = err_t_new_s | (err_timeout_q & ~err_clear);
  end

  // State and output registers.
  always_ff @(posedge ext_clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_q       <= IDLE;
      gap_q         <= {CNT_W{1'b0}};
      good_cnt_q    <= {GC_W{1'b0}};
      idx_q         <= {IDX_W{1'b0}};
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      phase_q       <= {NUM_PHASES{1'b0}};
      phase_idx_q   <= {IDX_W{1'b0}};
      locked_q      <= 1'b0;
      half_cnt_q    <= {CNT_W{1'b0}};
      err_period_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      good_cnt_q    <= good_cnt_d;
      idx_q         <= idx_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      phase_q       <= phase_d;
      phase_idx_q   <= phase_idx_d;
      locked_q      <= locked_d;
      half_cnt_q    <= half_cnt_d;
      err_period_q  <= err_period_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign rise        = rise_q;
  assign fall        = fall_q;
  assign phase       = phase_q;
  assign phase_idx   = phase_idx_q;
  assign locked      = locked_q;
  assign half_cnt    = half_cnt_q;
  assign err_period  = err_period_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_clk_phase_decoder.sv
// Scoreboard bench: each clk_in toggle pushes the expected strobe record from a
// transaction-level model; a monitor pops and compares whenever a strobe appears.
module tb_clk_phase_decoder;

  localparam int HP = 5;
  localparam int TOLP = 0;
  localparam int LC = 8;
  localparam int TO = 32;
  localparam int NP = 4;
  localparam int LAT = 4;

  logic       ext_clk = 1'b0;
  logic       ext_reset_n = 1'b0;
  logic       clk_in = 1'b0;
  logic       err_clear = 1'b0;
  logic       rise, fall, locked, err_period, err_timeout;
  logic [3:0] phase;
  logic [1:0] phase_idx;
  logic [7:0] half_cnt;

  clk_phase_decoder dut (
    .ext_clk     (ext_clk),
    .ext_reset_n (ext_reset_n),
    .clk_in      (clk_in),
    .err_clear   (err_clear),
    .rise        (rise),
    .fall        (fall),
    .phase       (phase),
    .phase_idx   (phase_idx),
    .locked      (locked),
    .half_cnt    (half_cnt),
    .err_period  (err_period),
    .err_timeout (err_timeout)
  );

  always #5 ext_clk = ~ext_clk;

  int cyc = 0;
  always @(posedge ext_clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int exp_cyc;
    bit is_rise;
    bit chk_half;
    int half;
    bit lk;
    int idx;
    bit ep;
    bit et;
  } rec_t;
  rec_t sbq[$];

  // Reference model: 0 = idle, 1 = acquiring, 2 = locked.
  int m_st = 0;
  int m_good = 0;
  int m_idx = 0;
  bit m_ep = 1'b0;
  bit m_et = 1'b0;
  int last_tgl = -1;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rise"}, rise, 0);
    chk({tag, "_fall"}, fall, 0);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_phase_idx"}, phase_idx, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_half_cnt"}, half_cnt, 0);
    chk({tag, "_err_period"}, err_period, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  // Toggle clk_in now, predict the resulting strobe, then hold the level d cycles.
  // clr requests err_clear to be sampled on the same edge that processes this toggle.
  task automatic edge_ev(input int d, input bit clr);
    rec_t r;
    int now;
    int gap;
    bit good;
    bit newp;
    now = cyc;
    clk_in = ~clk_in;
    gap = (last_tgl < 0) ? 0 : (now - last_tgl);
    r.exp_cyc  = now + LAT;
    r.is_rise  = clk_in;
    r.chk_half = (last_tgl >= 0);
    r.half     = (gap > 255) ? 255 : gap;
    if (m_st != 0 && last_tgl >= 0 && gap >= TO) begin
      m_st = 0;
      m_et = 1'b1;
    end
    r.lk  = (m_st == 2);
    r.idx = r.lk ? m_idx : 0;
    good = (gap >= HP - TOLP) && (gap <= HP + TOLP);
    newp = 1'b0;
    if (m_st == 0) begin
      m_st = 1;
      m_good = 0;
    end else if (m_st == 1) begin
      if (good) begin
        m_good++;
        if (m_good == LC) begin
          m_st = 2;
          m_idx = 0;
        end
      end else begin
        m_good = 0;
      end
    end else begin
      if (!good) begin
        m_st = 1;
        m_good = 0;
        m_idx = 0;
        newp = 1'b1;
      end else if (r.is_rise) begin
        m_idx = (m_idx + 1) % NP;
      end
    end
    m_ep = newp | (m_ep & ~clr);
    m_et = m_et & ~clr;
    r.ep = m_ep;
    r.et = m_et;
    sbq.push_back(r);
    last_tgl = now;
    for (int i = 0; i < d; i++) begin
      err_clear = clr && (i == LAT - 1);
      @(negedge ext_clk);
    end
    err_clear = 1'b0;
  endtask

  // Monitor: pop and compare on every strobe; flag strobes that never came.
  always @(negedge ext_clk) begin : monitor
    rec_t r;
    if (ext_reset_n) begin
      if (sbq.size() > 0 && sbq[0].exp_cyc < cyc) begin
        r = sbq.pop_front();
        chk("strobe_missing_at", cyc, r.exp_cyc);
      end
      if (rise || fall) begin
        if (sbq.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          r = sbq.pop_front();
          chk("strobe_cycle", cyc, r.exp_cyc);
          chk("rise", rise, r.is_rise);
          chk("fall", fall, !r.is_rise);
          if (r.chk_half) chk("half_cnt", half_cnt, r.half);
          chk("locked", locked, r.lk);
          chk("phase_idx", phase_idx, r.lk ? r.idx : 0);
          chk("phase", phase, r.lk ? (1 << r.idx) : 0);
          chk("err_period", err_period, r.ep);
          chk("err_timeout", err_timeout, r.et);
        end
      end
    end
  end

  initial begin
    int d;
    bit clr;
    repeat (3) @(negedge ext_clk);
    chk_all_zero("reset");
    ext_reset_n = 1'b1;
    repeat (3) @(negedge ext_clk);

    // Acquire lock, then walk the phase ring through 12 rises.
    repeat (12) edge_ev(HP, 1'b0);
    repeat (24) edge_ev(HP, 1'b0);

    // One long half-period breaks lock, then re-acquire.
    edge_ev(7, 1'b0);
    repeat (11) edge_ev(HP, 1'b0);

    // Frozen input: timeout, then resume and re-lock.
    edge_ev(40, 1'b0);
    repeat (12) edge_ev(HP, 1'b0);

    // Clear coinciding with a fresh bad edge, then a clear on its own.
    edge_ev(6, 1'b0);
    edge_ev(HP, 1'b1);
    repeat (10) edge_ev(HP, 1'b0);
    edge_ev(HP, 1'b1);
    repeat (3) edge_ev(HP, 1'b0);

    // Randomised half-periods with occasional clears.
    repeat (80) begin
      d = ($urandom_range(0, 7) < 6) ? HP : $urandom_range(4, 7);
      clr = ($urandom_range(0, 9) == 0);
      edge_ev(d, clr);
    end

    // Gap counter saturation, then re-lock.
    edge_ev(300, 1'b0);
    repeat (12) edge_ev(HP, 1'b0);

    // Asynchronous reset in the middle of a locked period.
    if (clk_in) edge_ev(HP, 1'b0);
    chk("pre_reset_locked", locked, (m_st == 2) ? 1 : 0);
    @(negedge ext_clk);
    #2 ext_reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge ext_clk);
    sbq.delete();
    ext_reset_n = 1'b1;
    m_st = 0; m_good = 0; m_idx = 0; m_ep = 1'b0; m_et = 1'b0; last_tgl = -1;
    repeat (3) @(negedge ext_clk);
    repeat (12) edge_ev(HP, 1'b0);
    repeat (10) @(negedge ext_clk);

    chk("scoreboard_left", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
